// File: rtl/add_arbiter_pkg.sv
// Shared defaults and requester indices for the shared-adder arbiter.
// Requesters in the pipelined core are PC+4, branch target and address generation.
package add_arbiter_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_NUM_REQ = 3;
  localparam int DEF_ID_W    = 2;

  localparam int REQ_PC  = 0;
  localparam int REQ_BR  = 1;
  localparam int REQ_AGU = 2;

endpackage

// File: rtl/add_arbiter_rr_arbiter.sv
// Combinational round-robin picker: starting at ptr and wrapping modulo NUM_REQ,
// the first set request bit wins. It produces a one-hot grant plus its encoded index.
module add_arbiter_rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_valid
);

  logic [ID_W-1:0] idx;

  always_comb begin
    grant       = '0;
    grant_id    = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!grant_valid && req[idx]) begin
        grant[idx]  = 1'b1;
        grant_id    = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/add_arbiter.sv
// Shares one adder among NUM_REQ requesters using round-robin arbitration.
// It has a single registered result stage with backpressure and a synchronous flush.
module add_arbiter
  import add_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = DEF_ID_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_sum,
  output logic                      rsp_carry,
  output logic                      busy
);

  // Handshake: a requester transfers on a rising edge where req_valid[i] and req_ready[i]
  // are both high. The result transfers where rsp_valid and rsp_ready are both high.
  // Requesters hold their operands stable until they see their ready.

  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               grant_valid;
  logic               can_accept;
  logic               accept;
  logic [DATA_W-1:0]  a_sel;
  logic [DATA_W-1:0]  b_sel;
  logic [DATA_W:0]    sum_ext;
  logic [ID_W-1:0]    next_ptr;

  add_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req         (req_valid),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  // A full register that drains can be refilled in the same cycle.
  // reset_n gates the grant so that no requester sees ready while reset is held.
  assign can_accept = !rsp_valid || rsp_ready;
  assign accept     = grant_valid && can_accept && !flush && reset_n;
  assign req_ready  = accept ? grant : '0;

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        a_sel = req_a[i*DATA_W +: DATA_W];
        b_sel = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  assign sum_ext  = {1'b0, a_sel} + {1'b0, b_sel};
  assign next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
      rr_ptr    <= '0;
    end else if (flush) begin
      rsp_valid <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_id    <= grant_id;
      rsp_sum   <= sum_ext[DATA_W-1:0];
      rsp_carry <= sum_ext[DATA_W];
      rr_ptr    <= next_ptr;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign busy = rsp_valid;

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter: a per-cycle vector table plus hand-written
// sequences for backpressure, flush and asynchronous reset.
module tb_add_arbiter;
  import add_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int IW = 2;
  localparam int W  = 32;

  logic           clk;
  logic           reset_n;
  logic           flush;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_carry;
  logic           busy;

  int errors = 0;
  int checks = 0;

  add_arbiter #(.NUM_REQ(N), .ID_W(IW), .DATA_W(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   valid;
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    logic           rdy;
    logic           fl;
    logic [N-1:0]   exp_ready;
    logic           exp_valid;
    logic [IW-1:0]  exp_id;
    logic [W-1:0]   exp_sum;
    logic           exp_carry;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                       input logic rdy, input logic fl);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    rsp_ready = rdy;
    flush     = fl;
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [IW-1:0] id,
                         input logic [W-1:0] sum, input logic c);
    chk({tag, "_valid"}, 64'(rsp_valid), 64'(v));
    chk({tag, "_busy"},  64'(busy),      64'(v));
    chk({tag, "_id"},    64'(rsp_id),    64'(id));
    chk({tag, "_sum"},   64'(rsp_sum),   64'(sum));
    chk({tag, "_carry"}, 64'(rsp_carry), 64'(c));
  endtask

  task automatic set_vec(input int n, input logic [N-1:0] v,
                         input logic [W-1:0] a0, input logic [W-1:0] a1, input logic [W-1:0] a2,
                         input logic [W-1:0] b0, input logic [W-1:0] b1, input logic [W-1:0] b2,
                         input logic [N-1:0] er, input logic ev, input logic [IW-1:0] eid,
                         input logic [W-1:0] es, input logic ec);
    vecs[n].valid     = v;
    vecs[n].a         = {a2, a1, a0};
    vecs[n].b         = {b2, b1, b0};
    vecs[n].rdy       = 1'b1;
    vecs[n].fl        = 1'b0;
    vecs[n].exp_ready = er;
    vecs[n].exp_valid = ev;
    vecs[n].exp_id    = eid;
    vecs[n].exp_sum   = es;
    vecs[n].exp_carry = ec;
  endtask

  initial begin
    // round robin from rr_ptr=0: A=i, B=10
    for (int r = 0; r < 6; r++)
      set_vec(r, 3'b111, 0, 1, 2, 10, 10, 10, 3'(1 << (r % 3)), 1'b1, IW'(r % 3), 32'(10 + r % 3), 1'b0);
    // single add with carry on req1, then drain (outputs hold)
    set_vec(6, 3'b010, 0, 32'hFFFF_FFFF, 0, 0, 32'h2, 0, 3'b010, 1'b1, 2'd1, 32'h1, 1'b1);
    set_vec(7, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 1'b0, 2'd1, 32'h1, 1'b1);
    // ptr=2, only req0 valid -> wrap to 0, ptr becomes 1
    set_vec(8, 3'b001, 3, 0, 0, 4, 0, 0, 3'b001, 1'b1, 2'd0, 32'd7, 1'b0);
    // skip: req0/req2 valid from ptr=1 -> 2,0,2
    set_vec(9,  3'b101, 100, 0, 200, 1, 0, 2, 3'b100, 1'b1, 2'd2, 32'd202, 1'b0);
    set_vec(10, 3'b101, 100, 0, 200, 1, 0, 2, 3'b001, 1'b1, 2'd0, 32'd101, 1'b0);
    set_vec(11, 3'b101, 100, 0, 200, 1, 0, 2, 3'b100, 1'b1, 2'd2, 32'd202, 1'b0);
    set_vec(12, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 1'b0, 2'd2, 32'd202, 1'b0);
    // carry with zero sum on req2
    set_vec(13, 3'b100, 0, 0, 32'h8000_0000, 0, 0, 32'h8000_0000, 3'b100, 1'b1, 2'd2, 32'h0, 1'b1);
    set_vec(14, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 1'b0, 2'd2, 32'h0, 1'b1);

    reset_n = 1'b0;
    drive(3'b111, '0, '0, 1'b1, 1'b0);
    #2;
    chk_rsp("reset", 1'b0, '0, '0, 1'b0);
    chk("reset_ready", 64'(req_ready), 64'(0));
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    drive('0, '0, '0, 1'b1, 1'b0);
    tick();

    // table-driven vectors
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].valid, vecs[i].a, vecs[i].b, vecs[i].rdy, vecs[i].fl);
      #1;
      chk($sformatf("v%0d_ready", i), 64'(req_ready), 64'(vecs[i].exp_ready));
      tick();
      chk_rsp($sformatf("v%0d", i), vecs[i].exp_valid, vecs[i].exp_id, vecs[i].exp_sum, vecs[i].exp_carry);
    end

    // backpressure: ptr=0, fill with req0 (1+1), then stall req2 for 4 cycles
    drive(3'b001, {32'd0, 32'd0, 32'd1}, {32'd0, 32'd0, 32'd1}, 1'b1, 1'b0);
    tick();
    chk_rsp("bp_fill", 1'b1, 2'd0, 32'd2, 1'b0);
    drive(3'b100, {32'd5, 32'd0, 32'd0}, {32'd6, 32'd0, 32'd0}, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("bp%0d_ready", c), 64'(req_ready), 64'(0));
      tick();
      chk_rsp($sformatf("bp%0d", c), 1'b1, 2'd0, 32'd2, 1'b0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(req_ready), 64'(3'b100));
    tick();
    chk_rsp("bp_result", 1'b1, 2'd2, 32'd11, 1'b0);
    req_valid = '0;
    tick();
    chk("bp_drain_valid", 64'(rsp_valid), 64'(0));

    // flush priority: ptr=0, all valid
    drive(3'b111, {32'd0, 32'd0, 32'd9}, {32'd0, 32'd0, 32'd9}, 1'b1, 1'b1);
    #1;
    chk("flush_ready", 64'(req_ready), 64'(0));
    tick();
    chk("flush_valid", 64'(rsp_valid), 64'(0));
    flush = 1'b0;
    #1;
    chk("post_flush_ready", 64'(req_ready), 64'(3'b001));
    tick();
    chk_rsp("post_flush", 1'b1, 2'd0, 32'd18, 1'b0);
    // flush beats a stalled full register
    drive('0, '0, '0, 1'b0, 1'b1);
    tick();
    chk("flush_full_valid", 64'(rsp_valid), 64'(0));
    chk("flush_full_sum", 64'(rsp_sum), 64'd18);
    flush = 1'b0;

    // reset mid-operation: ptr=1 before, accept req0 with 5+7
    drive(3'b001, {32'd0, 32'd0, 32'd5}, {32'd0, 32'd0, 32'd7}, 1'b1, 1'b0);
    #1;
    chk("rst_pre_ready", 64'(req_ready), 64'(3'b001));
    tick();
    chk_rsp("rst_pre", 1'b1, 2'd0, 32'd12, 1'b0);
    req_valid = 3'b111;
    #2 reset_n = 1'b0;
    #1;
    chk_rsp("rst_async", 1'b0, '0, '0, 1'b0);
    chk("rst_async_ready", 64'(req_ready), 64'(0));
    #1 reset_n = 1'b1;
    req_valid = 3'b011;
    #1;
    chk("rst_ptr_ready", 64'(req_ready), 64'(3'b001));
    tick();
    chk_rsp("rst_post0", 1'b1, 2'd0, 32'd12, 1'b0);
    #1;
    chk("rst_req1_ready", 64'(req_ready), 64'(3'b010));
    tick();
    chk_rsp("rst_post1", 1'b1, 2'd1, 32'd0, 1'b0);
    req_valid = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
